// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with hazard stall; define HAZARD_FWD_EN when a forwarding unit exists (load-use hazards only)
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [1:0]        id_branch_type,
    input  logic [3:0]        id_exe_cmd,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_wb_en,
    input  logic              id_is_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    output logic [1:0]        exe_branch_type,
    output logic [3:0]        exe_exe_cmd,
    output logic              exe_mem_read,
    output logic              exe_mem_write,
    output logic              exe_wb_en,
    output logic              exe_is_imm,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [REG_AW-1:0] exe_src1,
    output logic [REG_AW-1:0] exe_src2,
    output logic [REG_AW-1:0] exe_dest,
    output logic              exe_valid,
    output logic              hazard_stall
);
    localparam int W = 10 + 4 * DATA_W + 3 * REG_AW;
    logic [W-1:0] id_bus, stage_d, stage_q;
    logic         valid_d, valid_q;
    logic         src2_used, load_use, raw_hit;

    function automatic logic reads(input logic [REG_AW-1:0] d, s1, s2, input logic u2);
        return d != '0 && (d == s1 || (u2 && d == s2));
    endfunction

    assign id_bus = {id_branch_type, id_exe_cmd, id_mem_read, id_mem_write, id_wb_en, id_is_imm,
                     id_pc, id_val1, id_val2, id_st_val, id_src1, id_src2, id_dest};
    assign {exe_branch_type, exe_exe_cmd, exe_mem_read, exe_mem_write, exe_wb_en, exe_is_imm,
            exe_pc, exe_val1, exe_val2, exe_st_val, exe_src1, exe_src2, exe_dest} = stage_q;
    assign exe_valid = valid_q;
    assign src2_used = ~id_is_imm | id_mem_write;
    assign load_use  = valid_q & exe_mem_read & reads(exe_dest, id_src1, id_src2, src2_used);
`ifdef HAZARD_FWD_EN
    logic unused_mem;
    assign unused_mem = ^{mem_wb_en, mem_dest};
    assign raw_hit = load_use;
`else
    assign raw_hit = load_use
                   | (valid_q & exe_wb_en & reads(exe_dest, id_src1, id_src2, src2_used))
                   | (mem_wb_en & reads(mem_dest, id_src1, id_src2, src2_used));
`endif
    assign hazard_stall = raw_hit & ~flush & ~rst;

    // next stage contents: flush bubble, then freeze hold, then stall bubble, else capture ID
    always_comb begin
        stage_d = flush ? '0 : freeze ? stage_q : hazard_stall ? '0 : id_bus;
        valid_d = flush ? 1'b0 : freeze ? valid_q : !hazard_stall;
    end

    // stage register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: directed checks of capture, stalls, flush and freeze
module tb_id_exe_stage_reg;
`ifdef HAZARD_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    logic        clk = 1'b0, rst, freeze, flush;
    logic [1:0]  id_branch_type, exe_branch_type;
    logic [3:0]  id_exe_cmd, exe_exe_cmd;
    logic        id_mem_read, id_mem_write, id_wb_en, id_is_imm;
    logic        exe_mem_read, exe_mem_write, exe_wb_en, exe_is_imm, exe_valid, hazard_stall;
    logic [31:0] id_pc, id_val1, id_val2, id_st_val, exe_pc, exe_val1, exe_val2, exe_st_val;
    logic [4:0]  id_src1, id_src2, id_dest, exe_src1, exe_src2, exe_dest, mem_dest;
    logic        mem_wb_en;
    logic [159:0] all_o;
    int n_cmp = 0, n_err = 0;

    id_exe_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_branch_type(id_branch_type), .id_exe_cmd(id_exe_cmd), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_wb_en(id_wb_en), .id_is_imm(id_is_imm),
        .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val),
        .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .exe_branch_type(exe_branch_type), .exe_exe_cmd(exe_exe_cmd), .exe_mem_read(exe_mem_read),
        .exe_mem_write(exe_mem_write), .exe_wb_en(exe_wb_en), .exe_is_imm(exe_is_imm),
        .exe_pc(exe_pc), .exe_val1(exe_val1), .exe_val2(exe_val2), .exe_st_val(exe_st_val),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_valid(exe_valid), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    assign all_o = {6'b0, exe_valid, exe_branch_type, exe_exe_cmd, exe_mem_read, exe_mem_write,
                    exe_wb_en, exe_is_imm, exe_pc, exe_val1, exe_val2, exe_st_val,
                    exe_src1, exe_src2, exe_dest};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        {id_branch_type, id_exe_cmd, id_mem_read, id_mem_write, id_wb_en, id_is_imm} = '0;
        {id_pc, id_val1, id_val2, id_st_val, id_src1, id_src2, id_dest} = '0;
    endtask

    task automatic ld(input logic [4:0] d);
        clear_id();
        id_mem_read = 1'b1;
        id_wb_en    = 1'b1;
        id_dest     = d;
    endtask

    task automatic alu(input logic [3:0] cmd, input logic [4:0] s1, s2, d);
        clear_id();
        id_exe_cmd = cmd;
        id_wb_en   = 1'b1;
        id_src1    = s1;
        id_src2    = s2;
        id_dest    = d;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; mem_wb_en = 1'b0; mem_dest = '0;
        {id_branch_type, id_exe_cmd} = 6'($urandom);
        {id_mem_read, id_mem_write, id_wb_en, id_is_imm} = 4'($urandom);
        id_pc = $urandom; id_val1 = $urandom; id_val2 = $urandom; id_st_val = $urandom;
        {id_src1, id_src2, id_dest} = 15'($urandom);
        #1 chk("rst_stall", hazard_stall, 0);
        tick(); chk("rst_out0", all_o, 0); chk("rst_stall0", hazard_stall, 0);
        tick(); chk("rst_out1", all_o, 0); chk("rst_stall1", hazard_stall, 0);
        rst = 1'b0; clear_id(); id_exe_cmd = 4'b0101; id_val1 = 32'h1234;
        #1 chk("first_stall", hazard_stall, 0);
        tick(); chk("first_cmd", exe_exe_cmd, 4'b0101); chk("first_val1", exe_val1, 32'h1234);
        chk("first_valid", exe_valid, 1);
        ld(5); id_src1 = 5'd2;
        #1 chk("ld5_stall", hazard_stall, 0);
        tick(); chk("ld5_rd", exe_mem_read, 1);
        alu(4'd1, 5'd5, 5'd6, 5'd8); id_val1 = 32'd11;
        #1 chk("lu_stall", hazard_stall, 1);
        tick(); chk("lu_bubble", all_o, 0); chk("lu_stall_end", hazard_stall, 0);
        tick(); chk("lu_add_valid", exe_valid, 1); chk("lu_add_dest", exe_dest, 8);
        chk("lu_add_val1", exe_val1, 11);
        ld(7);
        tick();
        alu(4'd1, 5'd1, 5'd7, 5'd9); id_is_imm = 1'b1;
        #1 chk("addi_stall", hazard_stall, 0);
        tick(); chk("addi_dest", exe_dest, 9); chk("addi_valid", exe_valid, 1);
        ld(7);
        tick();
        clear_id(); id_mem_write = 1'b1; id_is_imm = 1'b1; id_src2 = 5'd7; id_st_val = 32'hCAFE;
        #1 chk("st_stall", hazard_stall, 1);
        tick(); chk("st_bubble", exe_valid, 0); chk("st_stall_end", hazard_stall, 0);
        tick(); chk("st_mw", exe_mem_write, 1); chk("st_val", exe_st_val, 32'hCAFE);
        ld(4);
        tick();
        alu(4'd1, 5'd4, 5'd0, 5'd9); flush = 1'b1;
        #1 chk("flush_stall", hazard_stall, 0);
        tick(); chk("flush_bubble", all_o, 0);
        flush = 1'b0; clear_id(); id_exe_cmd = 4'd3; id_val1 = 32'hAA; id_dest = 5'd10;
        tick(); chk("frz_load", exe_val1, 32'hAA);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_val1 = 32'(i + 100); id_exe_cmd = 4'(i + 7);
            tick();
            chk("frz_val1", exe_val1, 32'hAA); chk("frz_cmd", exe_exe_cmd, 3);
            chk("frz_valid", exe_valid, 1);
        end
        flush = 1'b1;
        tick(); chk("frz_flush", all_o, 0);
        flush = 1'b0; freeze = 1'b0; ld(6);
        tick();
        alu(4'd1, 5'd6, 5'd0, 5'd13); freeze = 1'b1;
        #1 chk("frzhz_stall", hazard_stall, 1);
        tick(); chk("frzhz_hold", exe_dest, 6); chk("frzhz_rd", exe_mem_read, 1);
        chk("frzhz_stall2", hazard_stall, 1);
        freeze = 1'b0;
        tick(); chk("frzhz_bubble", exe_valid, 0); chk("frzhz_stall3", hazard_stall, 0);
        tick(); chk("frzhz_add", exe_dest, 13);
        ld(0);
        tick();
        alu(4'd1, 5'd0, 5'd0, 5'd2);
        #1 chk("r0_stall", hazard_stall, 0);
        tick();
        alu(4'd1, 5'd1, 5'd1, 5'd3);
        #1 chk("add3_stall", hazard_stall, 0);
        tick();
        alu(4'd2, 5'd3, 5'd4, 5'd12);
        #1 chk("raw_exe_stall", hazard_stall, !FWD);
        tick(); chk("raw_exe_valid", exe_valid, FWD);
        mem_wb_en = 1'b1; mem_dest = 5'd3;
        #1 chk("raw_mem_stall", hazard_stall, !FWD);
        tick(); chk("raw_mem_valid", exe_valid, FWD);
        mem_wb_en = 1'b0;
        #1 chk("raw_done_stall", hazard_stall, 0);
        tick(); chk("raw_sub_valid", exe_valid, 1); chk("raw_sub_dest", exe_dest, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
